recovery_walker: RTL
====================

// Module: recovery_walker
// PURPOSE
// Downstream consumer of the branch checkpoint store. When a checkpoint is
// presented for a mispredicted branch, it sequences recovery:
// - one-cycle pipeline flush and PC redirect;
// - a walk of the snapshot's not-ready mask, issuing one physical-register
//   ready-bit clear per cycle to the register ready table;
// - a done pulse at the end.
// Rename is stalled for the entire recovery.
// PARAMETERS
// NUM_PR   128  physical registers; width of the not-ready mask
// PR_W     7    physical register index width, $clog2(NUM_PR)
// TAG_W    5    ROB tag width
// PC_W     32   PC width
// PORTS
// clk              in   1       clock, rising edge
// reset            in   1       asynchronous, active-low reset
// checkpoint_valid in   1       snapshot valid this cycle (mispredict found)
// snap_rob_tag     in   TAG_W   ROB tag of the mispredicted branch
// snap_rdy_mask    in   NUM_PR  snapshot reset_reg_rdy_table; 1 = PR to clear
// redirect_target  in   PC_W    correct target PC from the ROB/branch unit
// rdy_clr_ready    in   1       ready table accepts a clear this cycle
// flush            out  1       one-cycle flush of younger-than-tag work
// flush_rob_tag    out  TAG_W   tag qualifying flush
// redirect_valid   out  1       one-cycle fetch redirect, same cycle as flush
// redirect_pc      out  PC_W    redirect address
// rdy_clr_valid    out  1       clear request valid
// rdy_clr_pr       out  PR_W    PR whose ready bit is cleared
// rename_stall     out  1       high while state != IDLE
// recover_done     out  1       one-cycle pulse when recovery completes
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE; internal mask/tag/pc registers = 0;
//   all outputs = 0.
// - FSM states: IDLE -> FLUSH -> WALK -> DONE -> IDLE.
// - IDLE:
//   - On checkpoint_valid, latch snap_rdy_mask, snap_rob_tag and
//     redirect_target; go to FLUSH.
// - FLUSH (exactly 1 cycle):
//   - flush=1, redirect_valid=1;
//   - flush_rob_tag and redirect_pc driven from the latched values;
//   - go to WALK.
// - WALK:
//   - If the latched mask is all zero, go to DONE with no clear issued.
//   - Otherwise rdy_clr_valid=1 and rdy_clr_pr = index of the lowest set bit.
//   - On valid&&rdy_clr_ready, clear that mask bit.
//   - rdy_clr_pr is held stable while valid&&!ready.
//   - After the last bit is accepted, go to DONE in the next cycle.
// - DONE (1 cycle): recover_done=1; go to IDLE.
// - rename_stall = (state != IDLE), registered from state; it is low again
//   in the cycle after DONE.
// - Latency, with rdy_clr_ready held high and popcount(mask) = N:
//   - checkpoint_valid in cycle T -> flush in T+1;
//   - clears in T+2 .. T+1+N;
//   - recover_done in T+2+N.
// - Preemption: checkpoint_valid in FLUSH, WALK or DONE overwrites the
//   latched mask/tag/pc (no OR-merge) and re-enters FLUSH next cycle. An
//   older branch's mask covers all PRs of younger ones, so replace is
//   correct. A clear accepted in the same cycle still completes.
// - rdy_clr_valid, flush and redirect_valid are never high in the same
//   cycle.
// - Outputs in the other non-active states: rdy_clr_pr = 0 when
//   rdy_clr_valid = 0; flush_rob_tag and redirect_pc = 0 outside FLUSH.
// - Reset asserted mid-walk: recovery is abandoned immediately; no further
//   clears are issued.
// - Mask bit NUM_PR-1 (index 127) must be reachable; there is no
//   off-by-one at the top bit.
// TESTING
// 1. checkpoint_valid, mask={bits 3,9,127}, tag=5, target=0x100, ready=1
//    -> flush/redirect(0x100, tag 5) at T+1; clears 3,9,127 at T+2..T+4;
//    done at T+5.
// 2. Empty mask -> flush at T+1, no rdy_clr_valid, done at T+2;
//    rename_stall high T+1..T+2.
// 3. Mask={bit 0,1}, rdy_clr_ready low 3 cycles at first clear -> PR 0 held
//    4 cycles, then PR 1; done 1 cycle after the PR 1 accept.
// 4. During WALK (one of 3 bits cleared), new checkpoint_valid,
//    mask={bit 40}, tag=2 -> flush tag 2 next cycle, only PR 40 cleared,
//    single done.
// 5. reset driven low mid-WALK, asynchronously between edges -> all outputs
//    0 immediately, state IDLE; next checkpoint_valid starts a clean
//    sequence.
// 6. Random masks (1000 iterations) -> set of PRs cleared equals the mask
//    exactly, in ascending order, each exactly once.

Source files
------------

// File: rtl/recovery_walker_if.sv
// Recovery walker bus: checkpoint input, flush/redirect and
// ready-table clear channel, plus the rename stall and done pulse.
interface recovery_walker_if #(
  parameter int NUM_PR = 128,
  parameter int PR_W   = 7,
  parameter int TAG_W  = 5,
  parameter int PC_W   = 32
);
  logic              checkpoint_valid;
  logic [TAG_W-1:0]  snap_rob_tag;
  logic [NUM_PR-1:0] snap_rdy_mask;
  logic [PC_W-1:0]   redirect_target;
  logic              rdy_clr_ready;

  logic              flush;
  logic [TAG_W-1:0]  flush_rob_tag;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              rdy_clr_valid;
  logic [PR_W-1:0]   rdy_clr_pr;
  logic              rename_stall;
  logic              recover_done;

  modport master (
    output checkpoint_valid,
    output snap_rob_tag,
    output snap_rdy_mask,
    output redirect_target,
    output rdy_clr_ready,
    input  flush,
    input  flush_rob_tag,
    input  redirect_valid,
    input  redirect_pc,
    input  rdy_clr_valid,
    input  rdy_clr_pr,
    input  rename_stall,
    input  recover_done
  );

  modport slave (
    input  checkpoint_valid,
    input  snap_rob_tag,
    input  snap_rdy_mask,
    input  redirect_target,
    input  rdy_clr_ready,
    output flush,
    output flush_rob_tag,
    output redirect_valid,
    output redirect_pc,
    output rdy_clr_valid,
    output rdy_clr_pr,
    output rename_stall,
    output recover_done
  );
endinterface

// File: rtl/recovery_walker.sv
// Mispredict recovery sequencer: flush + redirect, then walk the
// snapshot not-ready mask clearing one PR per cycle, then done.
module recovery_walker #(
  parameter int NUM_PR = 128,
  parameter int PR_W   = $clog2(NUM_PR),
  parameter int TAG_W  = 5,
  parameter int PC_W   = 32
) (
  input logic clk,
  input logic reset,
  recovery_walker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    WALK,
    DONE
  } state_t;

  localparam logic [NUM_PR-1:0] ONE = NUM_PR'(1);

  state_t            state;
  state_t            state_nxt;
  logic [NUM_PR-1:0] mask_q;
  logic [TAG_W-1:0]  tag_q;
  logic [PC_W-1:0]   pc_q;

  logic [PR_W-1:0]   low_idx;
  logic              mask_any;
  logic              last_bit;
  logic              accept;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_PR - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = PR_W'(i);
    end
  end

  assign mask_any = |mask_q;
  // x & (x-1) drops the lowest set bit
  assign last_bit = (mask_q & (mask_q - ONE)) == '0;
  assign accept   = (state == WALK) && mask_any
                  && bus.rdy_clr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.checkpoint_valid) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (bus.checkpoint_valid) state_nxt = FLUSH;
        else if (mask_any)        state_nxt = WALK;
        else                      state_nxt = DONE;
      end
      WALK: begin
        if (bus.checkpoint_valid)      state_nxt = FLUSH;
        else if (!mask_any)            state_nxt = DONE;
        else if (accept && last_bit)   state_nxt = DONE;
      end
      DONE: begin
        if (bus.checkpoint_valid) state_nxt = FLUSH;
        else                      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a newer checkpoint replaces the walk outright; the older mask covers it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      tag_q  <= '0;
      pc_q   <= '0;
    end else if (bus.checkpoint_valid) begin
      mask_q <= bus.snap_rdy_mask;
      tag_q  <= bus.snap_rob_tag;
      pc_q   <= bus.redirect_target;
    end else if (accept) begin
      mask_q <= mask_q & (mask_q - ONE);
    end
  end

  always_comb begin
    bus.flush          = 1'b0;
    bus.flush_rob_tag  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.rdy_clr_valid  = 1'b0;
    bus.rdy_clr_pr     = '0;
    bus.recover_done   = 1'b0;
    bus.rename_stall   = (state != IDLE);
    unique case (state)
      IDLE: begin
      end
      FLUSH: begin
        bus.flush          = 1'b1;
        bus.flush_rob_tag  = tag_q;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc_q;
      end
      WALK: begin
        bus.rdy_clr_valid = mask_any;
        bus.rdy_clr_pr    = mask_any ? low_idx : '0;
      end
      DONE: begin
        bus.recover_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  a_excl: assert property (
    @(posedge clk) disable iff (!reset)
    !(bus.rdy_clr_valid && bus.flush)
  );

  a_hold: assert property (
    @(posedge clk) disable iff (!reset)
    (bus.rdy_clr_valid && !bus.rdy_clr_ready
      && !bus.checkpoint_valid)
    |=> (bus.rdy_clr_valid && $stable(bus.rdy_clr_pr))
  );

endmodule
